// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit holding architectural HI/LO.
// Results are computed at issue and committed after a fixed busy window.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic [3:0]  md_op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;

    typedef enum logic {StIdle, StRun} state_e;

    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [31:0]     r_hi, w_hi_d, r_lo, w_lo_d;
    logic [31:0]     r_res_hi, w_res_hi_d, r_res_lo, w_res_lo_d;
    logic            r_res_wr, w_res_wr_d;

    logic [63:0] w_smul, w_umul;
    logic [31:0] w_a_mag, w_b_mag, w_dvd, w_dvs, w_uq, w_ur;
    logic [31:0] w_sq, w_sr;
    logic        w_signed_div, w_b_zero;

    assign w_smul = {{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b};
    assign w_umul = {32'd0, md_a} * {32'd0, md_b};

    // Signed divide via magnitudes; INT_MIN / -1 falls out as a wrap to INT_MIN.
    assign w_signed_div = (md_op == OpDiv);
    assign w_b_zero     = (md_b == 32'd0);
    assign w_a_mag      = md_a[31] ? (32'd0 - md_a) : md_a;
    assign w_b_mag      = md_b[31] ? (32'd0 - md_b) : md_b;
    assign w_dvd        = w_signed_div ? w_a_mag : md_a;
    assign w_dvs        = w_b_zero ? 32'd1 : (w_signed_div ? w_b_mag : md_b);
    assign w_uq         = w_dvd / w_dvs;
    assign w_ur         = w_dvd % w_dvs;
    assign w_sq         = (md_a[31] ^ md_b[31]) ? (32'd0 - w_uq) : w_uq;
    assign w_sr         = md_a[31] ? (32'd0 - w_ur) : w_ur;

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_hi_d     = r_hi;
        w_lo_d     = r_lo;
        w_res_hi_d = r_res_hi;
        w_res_lo_d = r_res_lo;
        w_res_wr_d = r_res_wr;
        case (r_state)
            StIdle: begin
                if (start) begin
                    case (md_op)
                        OpMult, OpMultu: begin
                            w_res_hi_d = (md_op == OpMult) ? w_smul[63:32] : w_umul[63:32];
                            w_res_lo_d = (md_op == OpMult) ? w_smul[31:0] : w_umul[31:0];
                            w_res_wr_d = 1'b1;
                            w_cnt_d    = CntW'(MULT_CYCLES);
                            w_state_d  = StRun;
                        end
                        OpDiv, OpDivu: begin
                            w_res_hi_d = w_signed_div ? w_sr : w_ur;
                            w_res_lo_d = w_signed_div ? w_sq : w_uq;
                            w_res_wr_d = !w_b_zero;
                            w_cnt_d    = CntW'(DIV_CYCLES);
                            w_state_d  = StRun;
                        end
                        OpMthi:  w_hi_d = md_a;
                        OpMtlo:  w_lo_d = md_a;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                w_cnt_d = r_cnt - CntW'(1);
                if (r_cnt == CntW'(1)) begin
                    w_state_d = StIdle;
                    if (r_res_wr) begin
                        w_hi_d = r_res_hi;
                        w_lo_d = r_res_lo;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_res_wr <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_hi     <= w_hi_d;
            r_lo     <= w_lo_d;
            r_res_hi <= w_res_hi_d;
            r_res_lo <= w_res_lo_d;
            r_res_wr <= w_res_wr_d;
        end
    end

    assign busy   = (r_state == StRun);
    assign hi     = r_hi;
    assign lo     = r_lo;
    assign md_out = (md_op == OpMfhi) ? r_hi : ((md_op == OpMflo) ? r_lo : 32'd0);

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed HI/LO results.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic [3:0]  md_op;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int n_cmp;
    int n_err;

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .md_a  (md_a),
        .md_b  (md_b),
        .md_op (md_op),
        .start (start),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo),
        .md_out(md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op = op;
        md_a  = a;
        md_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        md_op = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", hi, lo);
        end
        n_cmp++;
        if (md_out !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mdout: got %h want 0", md_out);
        end
    endtask

    task automatic test_mult();
        issue(4'd1, 32'hFFFF_FFFF, 32'd2);
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if (busy !== 1'b1 || hi !== 32'd0) begin
                n_err++;
                $display("FAIL mult_busy T+%0d: got busy=%b hi=%h want 1/0", k, busy, hi);
            end
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            n_err++;
            $display("FAIL mult_result: got busy=%b hi=%h lo=%h want 0/ffffffff/fffffffe",
                     busy, hi, lo);
        end
    endtask

    task automatic test_multu();
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL multu_busy T+%0d: got %b want 1", k, busy);
            end
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
            n_err++;
            $display("FAIL multu_result: got busy=%b hi=%h lo=%h want 0/00000001/fffffffe",
                     busy, hi, lo);
        end
    endtask

    task automatic test_div();
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        for (int k = 1; k <= 10; k++) begin
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL div_busy T+%0d: got %b want 1", k, busy);
            end
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_err++;
            $display("FAIL div_result: got busy=%b hi=%h lo=%h want 0/ffffffff/fffffffd",
                     busy, hi, lo);
        end
        issue(4'd4, 32'd7, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL divu0_busy T+%0d: got %b want 1", k, busy);
            end
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_err++;
            $display("FAIL divu0_unchanged: got busy=%b hi=%h lo=%h want 0/ffffffff/fffffffd",
                     busy, hi, lo);
        end
    endtask

    task automatic test_move();
        issue(4'd5, 32'h1234_5678, 32'd0);
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL mthi: got busy=%b hi=%h want 0/12345678", busy, hi);
        end
        md_op = 4'd7;
        start = 1'b1;
        #1;
        n_cmp++;
        if (md_out !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL mfhi: got %h want 12345678", md_out);
        end
        md_op = 4'd8;
        #1;
        n_cmp++;
        if (md_out !== 32'hFFFF_FFFD) begin
            n_err++;
            $display("FAIL mflo: got %h want fffffffd", md_out);
        end
        md_op = 4'd9;
        #1;
        n_cmp++;
        if (md_out !== 32'd0) begin
            n_err++;
            $display("FAIL mdout_op9: got %h want 0", md_out);
        end
        start = 1'b0;
        md_op = 4'd0;
        tick();
        // MTLO arriving while a MULT runs must be dropped.
        issue(4'd1, 32'd3, 32'd4);
        issue(4'd6, 32'hDEAD_BEEF, 32'd0);
        n_cmp++;
        if (busy !== 1'b1 || lo !== 32'hFFFF_FFFD) begin
            n_err++;
            $display("FAIL mtlo_busy: got busy=%b lo=%h want 1/fffffffd", busy, lo);
        end
        for (int k = 0; k < 4; k++) tick();
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd12) begin
            n_err++;
            $display("FAIL mtlo_ignored: got busy=%b hi=%h lo=%h want 0/0/0000000c", busy, hi, lo);
        end
    endtask

    task automatic test_reset_abort();
        issue(4'd1, 32'hFFFF_FFFF, 32'd2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL abort_reset: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
        for (int k = 0; k < 4; k++) tick();
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL abort_nowrite: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
        issue(4'd4, 32'd100, 32'd7);
        for (int k = 0; k < 10; k++) tick();
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
            n_err++;
            $display("FAIL divu_after_abort: got busy=%b hi=%h lo=%h want 0/2/14", busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(4'd1, 32'd5, 32'd5);
        for (int k = 2; k <= 10; k++) begin
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_busy T+%0d: got %b want 1", k, busy);
            end
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL divovf_result: got busy=%b hi=%h lo=%h want 0/0/80000000", busy, hi, lo);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || lo !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL b2b_mult_dropped: got busy=%b lo=%h want 0/80000000", busy, lo);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        md_op = 4'd0;
        md_a  = 32'd0;
        md_b  = 32'd0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_move();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide unit. It sits beside the ALU and consumes the same forwarded operand pair from the D/E register.
- It holds the architectural HI/LO registers and runs MULT/MULTU/DIV/DIVU as multi-cycle operations with a busy handshake to the hazard unit.
- It serves MTHI/MTLO writes and MFHI/MFLO reads. The read result is muxed with ALUOut into the E/M register.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be ≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be ≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- md_a  input  32  operand 1 (rs, forwarded).
- md_b  input  32  operand 2 (rt, forwarded).
- md_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9–15 treated as NONE.
- start  input  1  qualifies md_op for one cycle (1 = E-stage instruction valid).
- busy  output  1  operation in progress.
- hi  output  32  current HI.
- lo  output  32  current LO.
- md_out  output  32  MFHI→hi, MFLO→lo, else 0 (combinational).

Behaviour:
- Reset, checked at the clock edge:
  - hi, lo = 0; busy = 0; counter = 0; any pending result is discarded.
  - Reset overrides start in the same cycle.
  - Reset mid-operation aborts the operation. No late HI/LO write occurs.
- FSM states: IDLE, RUN.
- IDLE with start=1 and md_op in {1..4}, at the edge:
  - Compute the result into internal res_hi/res_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- RUN, each edge:
  - Counter decrements.
  - When counter==1 at the edge: hi←res_hi, lo←res_lo, busy→0, go to IDLE.
  - With start at cycle T, busy is high for exactly cycles T+1..T+N. New HI/LO are visible in cycle T+N+1.
- Arithmetic:
  - MULT: signed 32×32→64; hi = [63:32], lo = [31:0].
  - MULTU: unsigned 32×32→64; same split.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divisor 0 (DIV/DIVU): the busy sequence runs normally, but hi/lo are left unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
- MTHI/MTLO with start=1 in IDLE: hi (resp. lo) ← md_a at the edge. No busy.
- MFHI/MFLO: md_out combinational from the current hi/lo. A value written at an edge is readable in the next cycle.
- start=1 while busy=1 (any op except 7/8): ignored; the running operation is unaffected.
  - The hazard unit must stall D-stage MD ops while (start&&op∈1..6)||busy. The block does not rely on that guarantee.
- MFHI/MFLO while busy: returns the old value. The hazard unit stalls these, so the value is don't-care architecturally.
- start=0: md_op is ignored.

Test Plan:
- Reset, then MULT with md_a=0xFFFFFFFF, md_b=2 at cycle T (N=5) → busy=1 in T+1..T+5, 0 at T+6; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV md_a=0xFFFFFFF9 (−7), md_b=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 7/0 → busy for 10 cycles, hi/lo unchanged.
- MTHI 0x12345678, then MFHI next cycle → md_out=0x12345678. MTLO issued while busy from a MULT → ignored; lo ends with the MULT result.
- MULT start, then reset=1 at T+2 → at T+3 busy=0, hi=lo=0; no write at T+6. A new DIVU 100/7 afterwards → lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. A second MULT started at T+1 while busy → ignored; busy drops at exactly T+11.
